uart_rx_fifo: RTL and testbench



---
 rtl/uart_rx_fifo_pkg.sv | 5 +
 rtl/uart_rx_fifo_sync_fifo.sv | 49 ++++
 rtl/uart_rx_fifo.sv | 48 ++++
 tb/tb_uart_rx_fifo.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// uart_rx_fifo_pkg: shared UART widths and receive-buffer defaults
package uart_rx_fifo_pkg;
    localparam int UART_DATA_W   = 8;
    localparam int RX_FIFO_DEPTH = 16;
endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// sync_fifo: show-ahead synchronous FIFO with occupancy count, reusable on the TX side
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push, w_pop;

    assign full    = r_count == FULL_CNT;
    assign empty   = r_count == '0;
    assign count   = r_count;
    assign rd_data = empty ? '0 : r_mem[r_rd_ptr];
    assign w_pop   = pop & ~empty;
    assign w_push  = push & (~full | w_pop);

    // pointers wrap naturally at DEPTH; count tracks net push/pop
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + AW'(w_push);
            r_rd_ptr <= r_rd_ptr + AW'(w_pop);
            r_count  <= (w_push & ~w_pop) ? r_count + 1'b1 :
                        (w_pop & ~w_push) ? r_count - 1'b1 : r_count;
        end
    end

    // storage is deliberately left unreset
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= wr_data;
    end
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: captures each completed uart_rx byte into a FIFO and flags overruns
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH = RX_FIFO_DEPTH,
    parameter int WIDTH = UART_DATA_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rx_rdy,
    input  logic [WIDTH-1:0]           rx_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overrun,
    input  logic                       ovr_clr
);
    logic r_rdy_q, r_overrun;
    logic w_push, w_drop;

    assign w_push  = rx_rdy & ~r_rdy_q;
    assign w_drop  = w_push & full & ~rd_en;
    assign overrun = r_overrun;

    // rdy_q resets high so a byte already ready at reset release is not pushed
    always_ff @(posedge clk) begin
        r_rdy_q <= rst ? 1'b1 : rx_rdy;
    end

    // sticky overrun; a drop in the same cycle as a clear wins
    always_ff @(posedge clk) begin
        r_overrun <= rst ? 1'b0 : w_drop ? 1'b1 : ovr_clr ? 1'b0 : r_overrun;
    end

    sync_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (w_push),
        .wr_data (rx_data),
        .pop     (rd_en),
        .rd_data (rd_data),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;
    logic       clk = 0;
    logic       rst, rx_rdy, rd_en, ovr_clr;
    logic [7:0] rx_data, rd_data;
    logic       empty, full, overrun;
    logic [4:0] count;
    int checks = 0;
    int errors = 0;

    uart_rx_fifo #(.DEPTH(16), .WIDTH(8)) dut (
        .clk(clk), .rst(rst), .rx_rdy(rx_rdy), .rx_data(rx_data), .rd_en(rd_en),
        .rd_data(rd_data), .empty(empty), .full(full), .count(count),
        .overrun(overrun), .ovr_clr(ovr_clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        rx_data = d;
        rx_rdy  = 1;
        tick();
        rx_rdy  = 0;
        tick();
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        check(tag, rd_data, exp);
        rd_en = 1;
        tick();
        rd_en = 0;
    endtask

    initial begin
        rst = 1; rx_rdy = 0; rx_data = 0; rd_en = 0; ovr_clr = 0;
        tick(); tick();
        rst = 0;
        tick();
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_overrun", overrun, 0);
        check("rst_rd_data", rd_data, 0);

        rx_data = 8'h55; rx_rdy = 1;
        tick();
        check("lat_empty", empty, 0);
        check("lat_data", rd_data, 8'h55);
        repeat (19) tick();
        rx_rdy = 0;
        tick();
        check("hold_count", count, 1);
        check("hold_data", rd_data, 8'h55);
        check("hold_empty", empty, 0);
        pop_check("hold_pop", 8'h55);
        check("hold_drained", empty, 1);

        push(8'h01); push(8'h02); push(8'h03);
        check("three_count", count, 3);
        pop_check("pop1", 8'h01);
        pop_check("pop2", 8'h02);
        pop_check("pop3", 8'h03);
        check("three_empty", empty, 1);
        check("three_zero", rd_data, 0);

        for (int i = 0; i < 16; i++) push(8'(i));
        check("fill_full", full, 1);
        check("fill_count", count, 16);
        check("fill_no_ovr", overrun, 0);
        push(8'hAA);
        check("ovr_set", overrun, 1);
        check("ovr_count", count, 16);
        check("ovr_head", rd_data, 8'h00);
        ovr_clr = 1;
        tick();
        ovr_clr = 0;
        check("ovr_clr", overrun, 0);
        rx_data = 8'hCC; rx_rdy = 1; ovr_clr = 1;
        tick();
        rx_rdy = 0; ovr_clr = 0;
        check("ovr_set_wins", overrun, 1);
        tick();
        ovr_clr = 1;
        tick();
        ovr_clr = 0;
        check("ovr_clr2", overrun, 0);

        rx_data = 8'hBB; rx_rdy = 1; rd_en = 1;
        check("pp_head", rd_data, 8'h00);
        tick();
        rx_rdy = 0; rd_en = 0;
        tick();
        check("pp_count", count, 16);
        check("pp_no_ovr", overrun, 0);
        for (int i = 1; i < 16; i++) pop_check("wrap_pop", 8'(i));
        pop_check("wrap_last", 8'hBB);
        check("wrap_empty", empty, 1);

        rd_en = 1;
        repeat (5) tick();
        rd_en = 0;
        check("idle_count", count, 0);
        check("idle_empty", empty, 1);
        check("idle_ovr", overrun, 0);
        push(8'h3C);
        check("idle_push", rd_data, 8'h3C);
        check("idle_push_cnt", count, 1);
        pop_check("idle_pop", 8'h3C);

        rx_data = 8'h11; rx_rdy = 1;
        tick();
        check("pre_rst_cnt", count, 1);
        rst = 1;
        tick(); tick();
        rst = 0;
        tick(); tick();
        check("rst_hold_cnt", count, 0);
        check("rst_hold_empty", empty, 1);
        check("rst_hold_data", rd_data, 0);
        rx_rdy = 0;
        tick();
        rx_data = 8'h7E; rx_rdy = 1;
        tick();
        repeat (3) tick();
        check("post_rst_cnt", count, 1);
        check("post_rst_data", rd_data, 8'h7E);
        rx_rdy = 0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
